imem_loader: RTL and testbench

Writer side of the instruction-memory interface. It receives a little-endian byte stream over a valid/ready handshake and packs it into 32-bit words. Each word is written into the instruction memory's write port at consecutive word addresses from the reset vector. The core is held in reset while loading and released only after a complete, non-overflowing program load.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader.sv | 106 ++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a little-endian byte stream into words written to imem
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned      DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR   = RESET_VECTOR,
  parameter int unsigned      CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic             core_rst,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_count
);

  loader_state_t    state_q, state_d;
  logic [1:0]       lane_q;
  logic [XLEN-1:0]  word_q;
  logic [CNT_W-1:0] index_q;
  logic             last_q;

  logic xfer;
  logic room;
  logic restart;

  assign xfer    = in_valid && (state_q == S_LOAD);
  assign room    = index_q < CNT_W'(DEPTH_WORDS);
  assign restart = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd0;
      word_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        lane_q  <= 2'd0;
        word_q  <= '0;
        index_q <= '0;
        last_q  <= 1'b0;
      end else if (xfer) begin
        word_q[{lane_q, 3'b000} +: 8] <= in_data;
        lane_q <= lane_q + 2'd1;
        last_q <= in_last;
      end else if (state_q == S_WRITE && room) begin
        // index doubles as word_count; it stops at DEPTH_WORDS because a full memory diverts to ERR
        index_q <= index_q + 1'b1;
        word_q  <= '0;
        lane_q  <= 2'd0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    core_rst = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (xfer && (lane_q == 2'd3 || in_last)) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!room) begin
          state_d = S_ERR;
        end else begin
          mem_we  = 1'b1;
          state_d = last_q ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (start) state_d = S_LOAD;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr   = BASE_ADDR + XLEN'({index_q, 2'b00});
  assign mem_wdata  = word_q;
  assign word_count = index_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized and directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 3;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;
  logic [CW-1:0] word_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_acc = 0;
  int end_cyc = 0;

  logic [7:0]  prog[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_err;
  int          exp_wc;

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(core_rst), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Program-level model: words are 4-byte little-endian chunks, zero padded, truncated at DEPTH
  function automatic void build_exp();
    int nwords;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    nwords = (prog.size() + 3) / 4;
    for (int k = 0; k < nwords && k < int'(DEPTH); k++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < prog.size()) w = w | (32'(prog[4 * k + b]) << (8 * b));
      exp_addr.push_back(BASE + 32'(4 * k));
      exp_data.push_back(w);
    end
    exp_err = nwords > int'(DEPTH);
    exp_wc  = (nwords > int'(DEPTH)) ? int'(DEPTH) : nwords;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        chk("we_in_ready", {31'h0, in_ready}, 32'h0);
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", mem_addr, 32'hxxxx_xxxx);
        end else begin
          chk("wr_addr", mem_addr, exp_addr.pop_front());
          chk("wr_data", mem_wdata, exp_data.pop_front());
        end
      end
      chk("core_rst_vs_done", {31'h0, core_rst}, {31'h0, ~done});
      chk("wc_saturate", {31'h0, word_count <= CW'(DEPTH)}, 32'h1);
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_ready", {31'h0, in_ready}, 32'h1);
    chk("start_core_rst", {31'h0, core_rst}, 32'h1);
    chk("start_done", {31'h0, done}, 32'h0);
    chk("start_err", {31'h0, err}, 32'h0);
    chk("start_wc", 32'(word_count), 32'h0);
  endtask

  task automatic send_prog(input int gap_pct, input bit noise, input bit with_last);
    int i = 0;
    int budget = 0;
    bit xfer;
    while (i < prog.size() && budget < 400) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = prog[i];
      in_last  = with_last && (i == prog.size() - 1);
      start    = noise && ($urandom_range(0, 7) == 0);
      xfer     = in_valid && in_ready;
      if (xfer && i == 0) first_acc = cyc;
      @(posedge clk);
      if (xfer) i++;
      budget++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    in_data  = 8'($urandom);
    if (i < prog.size()) chk("send_timeout", 32'(i), 32'(prog.size()));
  endtask

  task automatic wait_end(input bit want_err, input int want_wc);
    int n = 0;
    @(negedge clk);
    while (!(done || err) && n < 40) begin
      @(negedge clk);
      n++;
    end
    end_cyc = cyc;
    chk("end_done", {31'h0, done}, {31'h0, ~want_err});
    chk("end_err", {31'h0, err}, {31'h0, want_err});
    chk("end_core_rst", {31'h0, core_rst}, {31'h0, want_err});
    chk("end_wc", 32'(word_count), 32'(want_wc));
    chk("writes_left", 32'(exp_addr.size()), 32'h0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_core_rst", {31'h0, core_rst}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_wc", 32'(word_count), 32'h0);
  endtask

  function automatic void set_two_word();
    prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    exp_addr = '{32'h8000_0000, 32'h8000_0004};
    exp_data = '{32'h0050_0513, 32'h0010_0073};
  endfunction

  initial begin
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // two-word load, continuous valid, with throughput check
    do_start();
    set_two_word();
    send_prog(0, 1'b0, 1'b1);
    wait_end(1'b0, 2);
    chk("load_cycles", 32'(end_cyc - first_acc), 32'd10);

    // partial final word; start from DONE also covers reload
    do_start();
    prog = '{8'h93, 8'h00, 8'h10, 8'h00, 8'hAA};
    exp_addr = '{32'h8000_0000, 32'h8000_0004};
    exp_data = '{32'h0010_0093, 32'h0000_00AA};
    send_prog(0, 1'b0, 1'b1);
    wait_end(1'b0, 2);

    // backpressure gaps with ignored start pulses
    do_start();
    set_two_word();
    send_prog(40, 1'b1, 1'b1);
    wait_end(1'b0, 2);

    // overflow: third word finds memory full
    do_start();
    prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    exp_addr = '{32'h8000_0000, 32'h8000_0004};
    exp_data = '{32'h0403_0201, 32'h0807_0605};
    send_prog(0, 1'b0, 1'b1);
    wait_end(1'b1, 2);
    do_start();

    // reset after three bytes, then a clean one-word load
    prog = '{8'h11, 8'h22, 8'h33};
    exp_addr.delete();
    exp_data.delete();
    send_prog(0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    do_start();
    prog = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_addr = '{32'h8000_0000};
    exp_data = '{32'hDEAD_BEEF};
    send_prog(0, 1'b0, 1'b1);
    wait_end(1'b0, 1);

    // randomized programs against the model
    for (int t = 0; t < 30; t++) begin
      do_start();
      prog.delete();
      for (int b = 0, n = $urandom_range(1, 12); b < n; b++) prog.push_back(8'($urandom));
      build_exp();
      send_prog($urandom_range(0, 60), 1'b1, 1'b1);
      wait_end(exp_err, exp_wc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
